// File: rtl/dice_roller.sv
// Pseudo-random d4/d6/d8/d20 generator: 16-bit Fibonacci LFSR with multiply-shift range reduction.
// Optional macro DICE_ROLLER_HOLD_EN keeps the last result visible on idle cycles instead of clearing it.
module dice_roller #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] die_select,
   input  logic       roll,
   output logic [7:0] rolled_number
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] lfsr_r;
   logic [15:0] lfsr_next_s;
   logic [4:0]  faces_s;
   logic [12:0] product_s;
   logic [7:0]  result_s;
   logic [7:0]  rolled_next_s;

   // Feedback taps for x^16+x^14+x^13+x^11+1.
   function automatic logic lfsr_fb(input logic [15:0] l);
      return l[15] ^ l[13] ^ l[12] ^ l[10];
   endfunction

   // Next LFSR state, face count and scaled roll result.
   always_comb begin
      lfsr_next_s = {lfsr_r[14:0], lfsr_fb(lfsr_r)};
      case (die_select)
         2'b00:   faces_s = 5'd4;
         2'b01:   faces_s = 5'd6;
         2'b10:   faces_s = 5'd8;
         2'b11:   faces_s = 5'd20;
         default: faces_s = 5'd4;
      endcase
      product_s = {5'd0, lfsr_r[15:8]} * {8'd0, faces_s};
      result_s  = {3'd0, product_s[12:8]} + 8'd1;
      if (roll) begin
         rolled_next_s = result_s;
      end else begin
`ifdef DICE_ROLLER_HOLD_EN
         rolled_next_s = rolled_number;
`else
         rolled_next_s = 8'd0;
`endif
      end
   end

   // State and output registers; reset overrides roll and reseeds.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lfsr_r        <= SEED_EFF;
         rolled_number <= 8'd0;
      end else begin
         lfsr_r        <= lfsr_next_s;
         rolled_number <= rolled_next_s;
      end
   end

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: a reference LFSR model pushes expected outputs per driven cycle.
// Compile with DICE_ROLLER_HOLD_EN to match a hold-enabled RTL build.
module tb_dice_roller;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk;
   logic       reset_n;
   logic [1:0] die_select;
   logic       roll;
   logic [7:0] rolled_number;

   int          errors_cnt = 0;
   int          checks_cnt = 0;
   logic [15:0] m_lfsr;
   logic [7:0]  m_last;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_v;
   logic        seen[1:20];

   dice_roller #(.SEED(SEED)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .die_select   (die_select),
      .roll         (roll),
      .rolled_number(rolled_number)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
      checks_cnt++;
      if (act !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int faces_of(input logic [1:0] s);
      case (s)
         2'b00:   return 4;
         2'b01:   return 6;
         2'b10:   return 8;
         default: return 20;
      endcase
   endfunction

   function automatic logic [7:0] model_face(input logic [15:0] l, input logic [1:0] s);
      int prod;
      prod = int'(l[15:8]) * faces_of(s);
      return 8'((prod / 256) + 1);
   endfunction

   function automatic logic [15:0] model_step(input logic [15:0] l);
      logic fb;
      fb = l[15] ^ l[13] ^ l[12] ^ l[10];
      return {l[14:0], fb};
   endfunction

   // Push the model's prediction for this edge, advance the model.
   task automatic push_expect(input logic r, input logic [1:0] sel, input logic rst_v);
      logic [7:0] e;
      if (!rst_v) begin
         e      = 8'd0;
         m_lfsr = SEED;
      end else begin
         if (r) begin
            e = model_face(m_lfsr, sel);
         end else begin
`ifdef DICE_ROLLER_HOLD_EN
            e = m_last;
`else
            e = 8'd0;
`endif
         end
         m_lfsr = model_step(m_lfsr);
      end
      m_last = e;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      e = exp_q.pop_front();
      got_v = rolled_number;
      check_val(tag, rolled_number, e);
   endtask

   // One clock: drive, predict, wait for edge, sample 1 time unit later.
   task automatic cycle(input logic r, input logic [1:0] sel, input logic rst_v, input string tag);
      reset_n    = rst_v;
      roll       = r;
      die_select = sel;
      push_expect(r, sel, rst_v);
      @(posedge clk);
      #1;
      pop_check(tag);
   endtask

   initial begin
      m_lfsr     = 16'h0000;
      m_last     = 8'd0;
      reset_n    = 1'b0;
      roll       = 1'b1;
      die_select = 2'b00;

      // Reset held with roll high: output must stay 0.
      for (int i = 0; i < 10; i++) cycle(1'b1, 2'b00, 1'b0, "reset_hold");

      // First roll after reset for each die, against hand-computed constants.
      cycle(1'b1, 2'b00, 1'b1, "first_d4");
      check_val("first_d4_const", rolled_number, 8'd3);
      cycle(1'b1, 2'b01, 1'b0, "reseed");
      cycle(1'b1, 2'b01, 1'b1, "first_d6");
      check_val("first_d6_const", rolled_number, 8'd5);
      cycle(1'b1, 2'b10, 1'b0, "reseed");
      cycle(1'b1, 2'b10, 1'b1, "first_d8");
      check_val("first_d8_const", rolled_number, 8'd6);
      cycle(1'b1, 2'b11, 1'b0, "reseed");
      cycle(1'b1, 2'b11, 1'b1, "first_d20");
      check_val("first_d20_const", rolled_number, 8'd14);

      // Long back-to-back runs: range and full face coverage per die.
      for (int d = 0; d < 4; d++) begin
         for (int f = 1; f <= 20; f++) seen[f] = 1'b0;
         for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 2'(d), 1'b1, "run");
            check_val("range", {7'd0, (got_v >= 8'd1) && (int'(got_v) <= faces_of(2'(d)))}, 8'd1);
            if (got_v >= 8'd1 && got_v <= 8'd20) seen[got_v] = 1'b1;
         end
         for (int f = 1; f <= faces_of(2'(d)); f++) check_val("face_seen", {7'd0, seen[f]}, 8'd1);
      end

`ifndef DICE_ROLLER_HOLD_EN
      // Sub-cycle roll pulse between edges is not seen.
      cycle(1'b0, 2'b00, 1'b1, "idle");
      reset_n    = 1'b1;
      roll       = 1'b0;
      die_select = 2'b00;
      push_expect(1'b0, 2'b00, 1'b1);
      #2 roll = 1'b1;
      #2 roll = 1'b0;
      @(posedge clk);
      #1;
      pop_check("half_pulse");
      check_val("half_pulse_const", rolled_number, 8'd0);

      // Single roll: result for one cycle, then 0.
      cycle(1'b1, 2'b11, 1'b1, "single_roll");
      cycle(1'b0, 2'b11, 1'b1, "single_after");
      check_val("single_after_const", rolled_number, 8'd0);
`else
      // Hold build: a d20 roll right after reset is 14 and persists.
      cycle(1'b1, 2'b11, 1'b0, "reseed");
      cycle(1'b1, 2'b11, 1'b1, "hold_roll");
      check_val("hold_roll_const", rolled_number, 8'd14);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 2'b11, 1'b1, "hold_idle");
         check_val("hold_idle_const", rolled_number, 8'd14);
      end
      cycle(1'b1, 2'b11, 1'b1, "hold_update");
`endif

      // Reset on the edge after a roll clears output; post-reset sequence repeats.
      cycle(1'b1, 2'b00, 1'b1, "pre_reset_roll");
      cycle(1'b1, 2'b00, 1'b0, "mid_reset");
      check_val("mid_reset_const", rolled_number, 8'd0);
      cycle(1'b1, 2'b00, 1'b1, "post_reset_d4");
      check_val("post_reset_d4_const", rolled_number, 8'd3);
      cycle(1'b0, 2'b00, 1'b1, "tail");

      $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
      $finish;
   end

endmodule
